// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - execute unit: single-cycle integer ops plus iterative MUL/DIV with HI/LO
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_s,
  input  logic             i_flush,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovf,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = SHW + 1;
  localparam int MSB  = WIDTH - 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  localparam logic [4:0] OP_AND   = 5'd0;
  localparam logic [4:0] OP_OR    = 5'd1;
  localparam logic [4:0] OP_XOR   = 5'd2;
  localparam logic [4:0] OP_NOR   = 5'd3;
  localparam logic [4:0] OP_ADD   = 5'd4;
  localparam logic [4:0] OP_SUB   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_MULT  = 5'd12;
  localparam logic [4:0] OP_MULTU = 5'd13;
  localparam logic [4:0] OP_DIV   = 5'd14;
  localparam logic [4:0] OP_DIVU  = 5'd15;
  localparam logic [4:0] OP_MFHI  = 5'd16;
  localparam logic [4:0] OP_MFLO  = 5'd17;
  localparam logic [4:0] OP_MTHI  = 5'd18;
  localparam logic [4:0] OP_MTLO  = 5'd19;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;            // multiplicand / divisor magnitude
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;  // partial product high half / remainder
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;  // multiplier / dividend shifting into quotient
  logic              neg_q, neg_d;        // product or quotient must be negated
  logic              rem_neg_q, rem_neg_d;
  logic              is_div_q, is_div_d;
  logic              dz_q, dz_d;          // divide by zero
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic [SHW-1:0]        shamt;
  logic [WIDTH-1:0]      add_sum, sub_dif, alu_res;
  logic signed [WIDTH-1:0] sra_val;
  logic                  alu_ovf;
  logic                  is_muldiv, signed_op, r_neg, s_neg;
  logic [WIDTH-1:0]      mag_r, mag_s;
  logic [WIDTH:0]        mul_sum, div_shift, div_dif;
  logic [2*WIDTH-1:0]    prod, prod_fix;
  logic [WIDTH-1:0]      quo_fix, rem_fix;

  assign shamt = i_r[SHW-1:0];

  // Single-cycle result and signed overflow for the op currently on the inputs
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    add_sum = i_r + i_s;
    sub_dif = i_r - i_s;
    sra_val = $signed(i_s) >>> shamt;
    case (i_op)
      OP_AND:  alu_res = i_r & i_s;
      OP_OR:   alu_res = i_r | i_s;
      OP_XOR:  alu_res = i_r ^ i_s;
      OP_NOR:  alu_res = ~(i_r | i_s);
      OP_ADD: begin
        alu_res = add_sum;
        alu_ovf = (i_r[MSB] == i_s[MSB]) && (add_sum[MSB] != i_r[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_dif;
        alu_ovf = (i_r[MSB] != i_s[MSB]) && (sub_dif[MSB] != i_r[MSB]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_r) < $signed(i_s))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (i_r < i_s)};
      OP_SLL:  alu_res = i_s << shamt;
      OP_SRL:  alu_res = i_s >> shamt;
      OP_SRA:  alu_res = sra_val;
      OP_LUI:  alu_res = i_s << (WIDTH / 2);
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_MTHI: alu_res = i_r;
      OP_MTLO: alu_res = i_r;
      default: alu_res = '0;
    endcase
  end

  // Operand magnitudes and sign flags latched when a MULT/DIV is accepted
  always_comb begin
    is_muldiv = (i_op == OP_MULT) || (i_op == OP_MULTU) || (i_op == OP_DIV) || (i_op == OP_DIVU);
    signed_op = (i_op == OP_MULT) || (i_op == OP_DIV);
    r_neg     = signed_op && i_r[MSB];
    s_neg     = signed_op && i_s[MSB];
    mag_r     = r_neg ? -i_r : i_r;
    mag_s     = s_neg ? -i_s : i_s;
  end

  // Control FSM and iterative datapath: shift-add multiply, restoring divide, sign fix-up
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    ovf_d     = 1'b0;

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[MSB]};
    div_dif   = div_shift - {1'b0, a_q};
    prod      = {acc_hi_q, acc_lo_q};
    prod_fix  = neg_q ? -prod : prod;
    // A zero divisor leaves the dividend as remainder naturally; only the quotient is forced
    quo_fix   = dz_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
    rem_fix   = rem_neg_q ? -acc_hi_q : acc_hi_q;

    case (state_q)
      S_IDLE: begin
        // A flush on the accepting edge squashes the op entirely
        if (i_valid && !i_flush) begin
          if (is_muldiv) begin
            state_d   = ((i_op == OP_DIV) || (i_op == OP_DIVU)) ? S_DIV : S_MUL;
            cnt_d     = CNT_LOAD;
            a_d       = mag_s;
            acc_hi_d  = '0;
            acc_lo_d  = mag_r;
            neg_d     = r_neg ^ s_neg;
            rem_neg_d = r_neg;
            is_div_d  = (i_op == OP_DIV) || (i_op == OP_DIVU);
            dz_d      = (i_s == '0);
          end else begin
            valid_d  = 1'b1;
            result_d = alu_res;
            ovf_d    = alu_ovf;
            if (i_op == OP_MTHI) hi_d = i_r;
            if (i_op == OP_MTLO) lo_d = i_r;
          end
        end
      end
      S_MUL: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[MSB:1]};
          cnt_d    = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_FIX;
        end
      end
      S_DIV: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else begin
          if (!div_dif[WIDTH]) begin
            acc_hi_d = div_dif[MSB:0];
            acc_lo_d = {acc_lo_q[MSB-1:0], 1'b1};
          end else begin
            acc_hi_d = div_shift[MSB:0];
            acc_lo_d = {acc_lo_q[MSB-1:0], 1'b0};
          end
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!i_flush) begin
          valid_d = 1'b1;
          if (is_div_q) begin
            hi_d     = rem_fix;
            lo_d     = quo_fix;
            result_d = quo_fix;
          end else begin
            hi_d     = prod_fix[2*WIDTH-1:WIDTH];
            lo_d     = prod_fix[MSB:0];
            result_d = prod_fix[MSB:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_ovf    = ovf_q;
  assign o_hi     = hi_q;
  assign o_lo     = lo_q;

endmodule
